// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the MIPS-lite datapath.
// Steps each instruction through FETCH / DECODE / EXEC / MEM_RD / MEM_WR / WB.
// It drives every datapath select, enable and write strobe, and holds the
// memory states for MEM_LAT cycles so the data memory has time to respond.
//
// Parameters:
//   MEM_LAT  data-memory access cycles per MEM state visit (1..15)
//   CNT_W    width of the retired-instruction counter
//
// Ports:
//   CLK, RESET          rising-edge clock; synchronous active-low reset
//   Instr               IR contents, stable from DECODE onward
//   Zero, Bgezal_op     ALU flags for beq / bgezal
//   PcWrite, IrWrite    PC and IR load enables
//   Regdst, Alusrc, Memtoreg, Extop, Npc_sel, Aluop   datapath selects
//   Memwrite, Regwrite  DM and GRF write strobes
//   If_lb, If_sb        byte-load and byte-store path selects
//   State               current FSM state code (debug)
//   Retired             completed-instruction count, wraps
//
// Build option: define ILLEGAL_TRAP_EN to send unknown encodings to a TRAP
// state that only reset can leave. Otherwise they retire as nops.
module multicycle_ctrl #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  input  logic             Bgezal_op,
  output logic             PcWrite,
  output logic             IrWrite,
  output logic [1:0]       Regdst,
  output logic             Alusrc,
  output logic [1:0]       Memtoreg,
  output logic             Memwrite,
  output logic             Regwrite,
  output logic [1:0]       Extop,
  output logic [1:0]       Npc_sel,
  output logic [2:0]       Aluop,
  output logic             If_lb,
  output logic             If_sb,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB     = 4'd5,
    S_TRAP   = 4'd6
  } state_e;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_SLL, I_JR, I_ORI, I_LUI, I_LW, I_LB,
    I_SW, I_SB, I_BEQ, I_J, I_JAL, I_BGEZAL, I_ILL
  } instr_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [3:0] LAT_M1   = 4'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  instr_e           kind;

  logic [5:0] opcode, funct;
  logic [4:0] rt;
  logic       unused_instr_bits;

  assign opcode = Instr[31:26];
  assign rt     = Instr[20:16];
  assign funct  = Instr[5:0];
  assign unused_instr_bits = ^{Instr[25:21], Instr[15:6]};

  always_comb begin
    kind = I_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: kind = I_ADDU;
          6'b100011: kind = I_SUBU;
          6'b000000: kind = I_SLL;
          6'b001000: kind = I_JR;
          default:   kind = I_ILL;
        endcase
      end
      6'b000001: if (rt == 5'b10001) kind = I_BGEZAL;
      6'b001101: kind = I_ORI;
      6'b001111: kind = I_LUI;
      6'b100011: kind = I_LW;
      6'b100000: kind = I_LB;
      6'b101011: kind = I_SW;
      6'b101000: kind = I_SB;
      6'b000100: kind = I_BEQ;
      6'b000010: kind = I_J;
      6'b000011: kind = I_JAL;
      default:   kind = I_ILL;
    endcase
  end

  // ALU/extender controls chosen in EXEC are held through MEM and WB so the
  // address and result paths stay stable until writeback.
  logic [1:0] ext_x;
  logic       alusrc_x;
  logic [2:0] aluop_x;

  always_comb begin
    ext_x    = 2'b00;
    alusrc_x = 1'b0;
    aluop_x  = ALU_ADD;
    case (kind)
      I_SUBU: aluop_x = ALU_SUB;
      I_SLL:  aluop_x = ALU_SLL;
      I_ORI:  begin alusrc_x = 1'b1; aluop_x = ALU_OR; end
      I_LUI:  begin ext_x = 2'b10; alusrc_x = 1'b1; aluop_x = ALU_PASS; end
      I_LW, I_LB, I_SW, I_SB: begin ext_x = 2'b01; alusrc_x = 1'b1; end
      I_BEQ:  aluop_x = ALU_SUB;
      default: ;
    endcase
  end

  logic pc_we, ir_we, mem_we, reg_we;

  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    Regdst    = 2'b00;
    Alusrc    = 1'b0;
    Memtoreg  = 2'b00;
    Extop     = 2'b00;
    Npc_sel   = 2'b00;
    Aluop     = ALU_ADD;
    If_lb     = 1'b0;
    If_sb     = 1'b0;

    if (state_q inside {S_EXEC, S_MEM_RD, S_MEM_WR, S_WB}) begin
      Extop  = ext_x;
      Alusrc = alusrc_x;
      Aluop  = aluop_x;
    end

    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (kind)
          I_J: begin
            pc_we = 1'b1; Npc_sel = 2'b10; state_d = S_FETCH;
          end
          I_JAL: begin
            pc_we = 1'b1; Npc_sel = 2'b10; state_d = S_FETCH;
            reg_we = 1'b1; Regdst = 2'b10; Memtoreg = 2'b10;
          end
          I_JR: begin
            pc_we = 1'b1; Npc_sel = 2'b11; state_d = S_FETCH;
          end
          I_ILL: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (kind)
          I_ADDU, I_SUBU, I_SLL, I_ORI, I_LUI: state_d = S_WB;
          I_LW, I_LB, I_SB: state_d = S_MEM_RD;
          I_SW: state_d = S_MEM_WR;
          I_BEQ: begin
            pc_we = Zero; Npc_sel = 2'b01; state_d = S_FETCH;
          end
          I_BGEZAL: begin
            pc_we = Bgezal_op; Npc_sel = 2'b01; state_d = S_FETCH;
            reg_we = 1'b1; Regdst = 2'b10; Memtoreg = 2'b10;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: begin
        if (cnt_q == '0) state_d = (kind == I_SB) ? S_MEM_WR : S_WB;
      end
      S_MEM_WR: begin
        If_sb = (kind == I_SB);
        if (cnt_q == '0) begin
          mem_we  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        Regdst   = (opcode == 6'b000000) ? 2'b01 : 2'b00;
        Memtoreg = (kind inside {I_LW, I_LB}) ? 2'b01 : 2'b00;
        If_lb    = (kind == I_LB);
        state_d  = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Wait counter reloads whenever a MEM state is newly entered,
    // including the MEM_RD -> MEM_WR hop of sb.
    if ((state_d inside {S_MEM_RD, S_MEM_WR}) && (state_d != state_q))
      cnt_d = LAT_M1;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 4'd1;
    else
      cnt_d = '0;

    retired_d = retired_q;
    if ((state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_TRAP))
      retired_d = retired_q + CNT_W'(1);
  end

  // Strobes are qualified by RESET so nothing fires in a reset cycle.
  assign PcWrite  = pc_we  & RESET;
  assign IrWrite  = ir_we  & RESET;
  assign Memwrite = mem_we & RESET;
  assign Regwrite = reg_we & RESET;
  assign State    = state_q;
  assign Retired  = retired_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

endmodule
